clkswitch_multi: RTL and testbench

//  Glitch-free CPU clock selector, fully synchronous to hsclk_in. Chooses between a

---
 rtl/clkswitch_multi_pkg.sv | 18 +
 rtl/clkswitch_multi_div.sv | 57 +++++
 rtl/clkswitch_multi.sv | 122 ++++++++++++
 tb/tb_clkswitch_multi.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/clkswitch_multi_pkg.sv
// Shared definitions for the glitch-free CPU clock selector: FSM state encodings
// and default parameter values.
package clkswitch_multi_pkg;

  localparam int CS_MAX_DIV      = 4;
  localparam int CS_DIV_W        = 2;
  localparam int CS_SYNC_STAGES  = 2;
  localparam int CS_DEL_PIPE_SZ  = 3;
  localparam int CS_DEL_W        = 2;

  typedef enum logic [1:0] {
    LS_RUN   = 2'b00,
    HS_ALIGN = 2'b01,
    HS_RUN   = 2'b10,
    LS_WAIT  = 2'b11
  } cs_state_t;

endpackage

// File: rtl/clkswitch_multi_div.sv
// Programmable hsclk divider: counter 0..N-1 with the ratio latched only at wrap,
// registered divided clock plus look-ahead strobes for the handover FSM.
module clkswitch_multi_div
  import clkswitch_multi_pkg::*;
#(
  parameter int MAX_DIV = CS_MAX_DIV,
  parameter int DIV_W   = CS_DIV_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [DIV_W-1:0] i_div_sel,
  output logic             o_fast,
  output logic             o_fast_nxt,
  output logic             o_cnt_zero_nxt,
  output logic             o_rise_nxt
);

  localparam int RAT_W = $clog2(MAX_DIV + 1);

  function automatic logic [RAT_W-1:0] ratio_of(input logic [DIV_W-1:0] sel);
    int n;
    n = int'(sel) + 2;
    if (n > MAX_DIV) n = MAX_DIV;
    return RAT_W'(n);
  endfunction

  logic [RAT_W-1:0] r_cnt;
  logic [RAT_W-1:0] r_ratio;
  logic [RAT_W-1:0] w_cnt_nxt;
  logic [RAT_W-1:0] w_ratio_nxt;
  logic [RAT_W:0]   w_half;
  logic             w_wrap;

  // New ratio takes effect only with the next period, so no phase is ever cut short.
  always_comb begin
    w_wrap         = (r_cnt == r_ratio - 1'b1);
    w_cnt_nxt      = w_wrap ? '0 : r_cnt + 1'b1;
    w_ratio_nxt    = w_wrap ? ratio_of(i_div_sel) : r_ratio;
    w_half         = ({1'b0, w_ratio_nxt} + 1'b1) >> 1;
    o_fast_nxt     = ({1'b0, w_cnt_nxt} < w_half);
    o_cnt_zero_nxt = (w_cnt_nxt == '0);
    o_rise_nxt     = o_fast_nxt & ~o_fast;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_ratio <= RAT_W'(2);
      o_fast  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_ratio <= w_ratio_nxt;
      o_fast  <= o_fast_nxt;
    end
  end

endmodule

// File: rtl/clkswitch_multi.sv
// Glitch-free CPU clock selector: switches clkout between a resynchronised, delayed
// host clock and a divided hsclk, always handing over while clkout is high (PHI2).
module clkswitch_multi
  import clkswitch_multi_pkg::*;
#(
  parameter int MAX_DIV     = CS_MAX_DIV,
  parameter int DIV_W       = CS_DIV_W,
  parameter int SYNC_STAGES = CS_SYNC_STAGES,
  parameter int DEL_PIPE_SZ = CS_DEL_PIPE_SZ,
  parameter int DEL_W       = CS_DEL_W
) (
  input  logic             hsclk_in,
  input  logic             rst,
  input  logic             lsclk_in,
  input  logic             hsclk_sel,
  input  logic [DIV_W-1:0] div_sel,
  input  logic [DEL_W-1:0] delay_sel,
  output logic             clkout,
  output logic             fast_clkout,
  output logic             hsclk_selected,
  output logic             lsclk_selected,
  output logic             switch_busy
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DEL_PIPE_SZ-1:0] r_del;
  logic [DEL_PIPE_SZ:0]   w_taps;
  logic [DEL_W-1:0]       w_tap_idx;
  logic                   w_ls_del;
  logic                   r_ls_prev;
  cs_state_t              r_state;
  cs_state_t              w_state_nxt;
  logic                   w_clk_nxt;
  logic                   r_clkout;
  logic                   r_hs_sel;
  logic                   r_ls_sel;
  logic                   r_busy;
  logic                   w_fast;
  logic                   w_fast_nxt;
  logic                   w_cnt_zero_nxt;
  logic                   w_rise_nxt;

  clkswitch_multi_div #(
    .MAX_DIV (MAX_DIV),
    .DIV_W   (DIV_W)
  ) u_div (
    .i_clk          (hsclk_in),
    .i_rst          (rst),
    .i_div_sel      (div_sel),
    .o_fast         (w_fast),
    .o_fast_nxt     (w_fast_nxt),
    .o_cnt_zero_nxt (w_cnt_zero_nxt),
    .o_rise_nxt     (w_rise_nxt)
  );

  // Host clock path: synchroniser, then delay taps matching the motherboard skew.
  always_ff @(posedge hsclk_in or posedge rst) begin
    if (rst) begin
      r_sync    <= '0;
      r_del     <= '0;
      r_ls_prev <= 1'b0;
    end else begin
      r_sync[0] <= lsclk_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_del[0] <= r_sync[SYNC_STAGES-1];
      for (int i = 1; i < DEL_PIPE_SZ; i++) r_del[i] <= r_del[i-1];
      r_ls_prev <= w_ls_del;
    end
  end

  always_comb begin
    w_taps    = {r_del, r_sync[SYNC_STAGES-1]};
    w_tap_idx = (int'(delay_sel) > DEL_PIPE_SZ) ? DEL_W'(DEL_PIPE_SZ) : delay_sel;
    w_ls_del  = w_taps[w_tap_idx];
  end

  // Both handover states park clkout high until the incoming source is also high.
  always_comb begin
    w_state_nxt = r_state;
    w_clk_nxt   = 1'b1;
    unique case (r_state)
      LS_RUN: begin
        w_clk_nxt = w_ls_del;
        if (hsclk_sel && w_ls_del && !r_ls_prev) w_state_nxt = HS_ALIGN;
      end
      HS_ALIGN: begin
        if (w_cnt_zero_nxt) w_state_nxt = HS_RUN;
      end
      HS_RUN: begin
        w_clk_nxt = w_fast_nxt;
        if (!hsclk_sel && w_rise_nxt) w_state_nxt = LS_WAIT;
      end
      LS_WAIT: begin
        if (w_ls_del) w_state_nxt = LS_RUN;
      end
      default: w_state_nxt = LS_RUN;
    endcase
  end

  always_ff @(posedge hsclk_in or posedge rst) begin
    if (rst) begin
      r_state  <= LS_RUN;
      r_clkout <= 1'b0;
      r_hs_sel <= 1'b0;
      r_ls_sel <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_clkout <= w_clk_nxt;
      r_hs_sel <= (w_state_nxt == HS_RUN);
      r_ls_sel <= (w_state_nxt == LS_RUN);
      r_busy   <= (w_state_nxt == HS_ALIGN) || (w_state_nxt == LS_WAIT);
    end
  end

  assign clkout         = r_clkout;
  assign fast_clkout    = w_fast;
  assign hsclk_selected = r_hs_sel;
  assign lsclk_selected = r_ls_sel;
  assign switch_busy    = r_busy;

endmodule

// File: tb/tb_clkswitch_multi.sv
// Bench for clkswitch_multi: host-clock delay line scoreboard, HS pattern queues,
// handover invariants, divider ratio change and async reset mid-handover.
`timescale 1ns/1ns
module tb_clkswitch_multi;

  logic       hsclk_in = 1'b0;
  logic       rst = 1'b1;
  logic       lsclk_in = 1'b0;
  logic       hsclk_sel = 1'b0;
  logic [1:0] div_sel = 2'd0;
  logic [1:0] delay_sel = 2'd2;
  logic       clkout, fast_clkout, hsclk_selected, lsclk_selected, switch_busy;
  bit         ls_run = 1'b1;

  int  n_total = 0;
  int  n_bad = 0;
  bit  q_ls[$];
  bit  q_pat[$];
  bit  ls_exp;

  clkswitch_multi dut (
    .hsclk_in       (hsclk_in),
    .rst            (rst),
    .lsclk_in       (lsclk_in),
    .hsclk_sel      (hsclk_sel),
    .div_sel        (div_sel),
    .delay_sel      (delay_sel),
    .clkout         (clkout),
    .fast_clkout    (fast_clkout),
    .hsclk_selected (hsclk_selected),
    .lsclk_selected (lsclk_selected),
    .switch_busy    (switch_busy)
  );

  // hsclk period 16, host clock period 256 (16 hsclk cycles), edges 11 after hsclk rise
  initial forever #8 hsclk_in = ~hsclk_in;
  initial begin
    #3;
    forever begin
      #128;
      lsclk_in = ls_run ? ~lsclk_in : 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Host clock reaches clkout 4 edges after sampling (2 sync + 2 taps, then the output flop).
  task automatic tick();
    @(posedge hsclk_in);
    #1;
    q_ls.push_back(lsclk_in);
    ls_exp = q_ls.pop_front();
  endtask

  task automatic reset_q();
    q_ls = {1'b0, 1'b0, 1'b0, 1'b0};
  endtask

  task automatic inv(input string tag);
    chk({tag, "_onehot"}, int'(hsclk_selected) + int'(lsclk_selected) + int'(switch_busy), 1);
    if (switch_busy) chk({tag, "_busy_high"}, clkout, 1);
    else if (hsclk_selected) chk({tag, "_hs_clk"}, clkout, fast_clkout);
    else if (lsclk_selected) chk({tag, "_ls_clk"}, clkout, ls_exp);
  endtask

  initial begin
    int  busy_cnt, hs_cnt, after, run, minrun;
    bit  ok, seen_busy, first, prev;

    reset_q();
    repeat (3) tick();
    chk("rst_clkout", clkout, 0);
    chk("rst_fast", fast_clkout, 0);
    chk("rst_hs_sel", hsclk_selected, 0);
    chk("rst_ls_sel", lsclk_selected, 1);
    chk("rst_busy", switch_busy, 0);
    rst = 1'b0;
    reset_q();
    div_sel = 2'd2;

    // host clock tracking with delay tap 2
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("ls_track", clkout, ls_exp);
    end
    chk("ls_selected", lsclk_selected, 1);

    // switch to hsclk /4
    hsclk_sel = 1'b1;
    ok = 0; busy_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      inv("to_hs");
      if (switch_busy) busy_cnt++;
      if (hsclk_selected) begin ok = 1; break; end
    end
    chk("to_hs_reached", ok, 1);
    chk("align_len_ok", int'(busy_cnt >= 1 && busy_cnt <= 4), 1);
    repeat (3) begin
      q_pat.push_back(1); q_pat.push_back(1); q_pat.push_back(0); q_pat.push_back(0);
    end
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      chk("hs_pat", clkout, q_pat.pop_front());
      inv("hs");
    end

    // back to host clock; no phase shorter than 2 hsclk cycles
    hsclk_sel = 1'b0;
    after = 0; seen_busy = 0; first = 1; prev = clkout; run = 1; minrun = 99;
    for (int i = 0; i < 120; i++) begin
      tick();
      inv("to_ls");
      if (switch_busy) seen_busy = 1;
      if (clkout == prev) run++;
      else begin
        if (!first && run < minrun) minrun = run;
        first = 0; run = 1; prev = clkout;
      end
      if (lsclk_selected) after++;
      if (after == 24) break;
    end
    chk("to_ls_reached", int'(after == 24), 1);
    chk("to_ls_busy_seen", seen_busy, 1);
    chk("to_ls_min_phase", int'(minrun >= 2 && minrun != 99), 1);

    // /2 -> /3 change mid-period
    div_sel = 2'd0;
    repeat (10) tick();
    ok = 0; prev = fast_clkout;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fast_clkout && !prev) begin ok = 1; break; end
      prev = fast_clkout;
    end
    chk("div_rise_found", ok, 1);
    div_sel = 2'd1;
    q_pat = {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("div_chg", fast_clkout, q_pat.pop_front());
    end

    // request withdrawn during HS_ALIGN
    div_sel = 2'd2;
    repeat (10) tick();
    hsclk_sel = 1'b1;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      inv("wd_a");
      if (switch_busy) begin ok = 1; break; end
    end
    chk("wd_busy_reached", ok, 1);
    hsclk_sel = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      inv("wd_b");
      if (hsclk_selected) begin ok = 1; break; end
    end
    chk("wd_hs_reached", ok, 1);
    hs_cnt = 0;
    for (int i = 0; i < 60 && hsclk_selected; i++) begin
      hs_cnt++;
      tick();
      inv("wd_c");
    end
    chk("wd_hs_full_period", int'(hs_cnt >= 4), 1);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (lsclk_selected) begin ok = 1; break; end
      tick();
      inv("wd_d");
    end
    chk("wd_ls_reached", ok, 1);

    // host clock stopped during LS_WAIT, then async reset
    hsclk_sel = 1'b1;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (hsclk_selected) begin ok = 1; break; end
    end
    chk("stop_hs_reached", ok, 1);
    ls_run = 1'b0;
    repeat (30) tick();
    hsclk_sel = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (switch_busy) begin ok = 1; break; end
    end
    chk("stop_busy_reached", ok, 1);
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("stop_busy_held", switch_busy, 1);
      chk("stop_clk_held", clkout, 1);
    end
    rst = 1'b1;
    #1;
    chk("arst_clkout", clkout, 0);
    chk("arst_fast", fast_clkout, 0);
    chk("arst_hs_sel", hsclk_selected, 0);
    chk("arst_ls_sel", lsclk_selected, 1);
    chk("arst_busy", switch_busy, 0);
    repeat (3) tick();
    rst = 1'b0;
    reset_q();
    ls_run = 1'b1;
    tick();
    chk("post_rst_clkout", clkout, 0);
    chk("post_rst_busy", switch_busy, 0);
    chk("post_rst_ls_sel", lsclk_selected, 1);
    chk("post_rst_hs_sel", hsclk_selected, 0);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("post_rst_track", clkout, ls_exp);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
